// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types for the L2 host tag controller
// Contents: default tag/stream sizing, tag and SID typedefs, controller FSM states.
package l2_pkg;

    localparam int L2_NTAGS  = 32;
    localparam int L2_NSTRMS = 64;

    typedef logic [$clog2(L2_NTAGS)-1:0]  l2_tag_t;
    typedef logic [$clog2(L2_NSTRMS)-1:0] l2_sid_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } l2_state_t;

endpackage

// File: rtl/l2_free_tag_fifo.sv
// rtl/l2_free_tag_fifo.sv - circular free list of host tags
// Ports: clk, reset (async, active-low); push/push_tag append at the tail;
//        pop removes pop_tag (the head); count = entries held; empty = count is 0.
// Push and pop may occur in the same cycle. empty/pop_tag are registered views,
// so a tag pushed this cycle is never visible to a pop in the same cycle.
module l2_free_tag_fifo #(
    parameter int ntags       = 32,
    parameter int ntags_width = $clog2(ntags)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [ntags_width-1:0] push_tag,
    input  logic                   pop,
    output logic [ntags_width-1:0] pop_tag,
    output logic [ntags_width:0]   count,
    output logic                   empty
);

    localparam logic [ntags_width-1:0] PTR_ONE = {{(ntags_width-1){1'b0}}, 1'b1};
    localparam logic [ntags_width:0]   CNT_ONE = {{ntags_width{1'b0}}, 1'b1};

    logic [ntags_width-1:0] mem [ntags];
    logic [ntags_width-1:0] wr_ptr;
    logic [ntags_width-1:0] rd_ptr;

    // Pointers wrap naturally because ntags is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the INIT sequence rewrites every slot before use.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    assign pop_tag = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/l2_host_tag_ctrl.sv
// rtl/l2_host_tag_ctrl.sv - host tag allocation, command issue and response-to-SID mapping
// Ports: i_req_* request in (SID, EA); o_cmd_* tagged host command out;
//        i_dat_* tagged host data in; o_rsp_* SID-mapped response out;
//        o_free_cnt free tag count; o_err sticky bad-tag flag.
// Reset: reset, asynchronous, active-low.
// Option macro: L2_TAG_CHECK_EN - tracks busy tags, drops responses to idle tags
//        and raises o_err; without it o_err is tied low.
module l2_host_tag_ctrl
    import l2_pkg::*;
#(
    parameter int addr_width   = 64,
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int ntags        = 32,
    parameter int ntags_width  = $clog2(ntags),
    parameter int data_width   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [nstrms_width-1:0] i_req_sid,
    input  logic [addr_width-1:0]   i_req_ea,
    output logic                    o_cmd_v,
    input  logic                    o_cmd_r,
    output logic [ntags_width-1:0]  o_cmd_tag,
    output logic [addr_width-1:0]   o_cmd_ea,
    input  logic                    i_dat_v,
    output logic                    i_dat_r,
    input  logic [ntags_width-1:0]  i_dat_tag,
    input  logic [data_width-1:0]   i_dat_d,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [nstrms_width-1:0] o_rsp_sid,
    output logic [data_width-1:0]   o_rsp_d,
    output logic [ntags_width:0]    o_free_cnt,
    output logic                    o_err
);

    localparam logic [ntags_width-1:0] LAST_TAG = ntags_width'(ntags - 1);
    localparam logic [ntags_width-1:0] K_ONE    = {{(ntags_width-1){1'b0}}, 1'b1};

    l2_state_t               state;
    l2_state_t               state_nxt;
    logic [ntags_width-1:0]  k;
    logic [ntags_width-1:0]  rsp_tag;
    logic [ntags_width-1:0]  head_tag;
    logic [ntags_width-1:0]  push_tag;
    logic                    push;
    logic                    fifo_empty;
    logic                    dat_ok;
    logic [nstrms_width-1:0] sid_tbl [ntags];

    logic req_acc, cmd_hs, dat_acc, rsp_hs;
    assign req_acc = i_req_v & i_req_r;
    assign cmd_hs  = o_cmd_v & o_cmd_r;
    assign dat_acc = i_dat_v & i_dat_r;
    assign rsp_hs  = o_rsp_v & o_rsp_r;

    l2_free_tag_fifo #(
        .ntags       (ntags),
        .ntags_width (ntags_width)
    ) u_free_list (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (push_tag),
        .pop      (req_acc),
        .pop_tag  (head_tag),
        .count    (o_free_cnt),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            k     <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) k <= k + K_ONE;
        end
    end

    // INIT seeds the free list with every tag; RUN recycles tags on response hand-off.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_tag  = k;
        i_req_r   = 1'b0;
        i_dat_r   = 1'b0;
        case (state)
            INIT: begin
                push = 1'b1;
                if (k == LAST_TAG) state_nxt = RUN;
            end
            RUN: begin
                i_req_r  = !fifo_empty && (!o_cmd_v || o_cmd_r);
                i_dat_r  = !o_rsp_v || o_rsp_r;
                push     = rsp_hs;
                push_tag = rsp_tag;
            end
            default: state_nxt = INIT;
        endcase
    end

`ifdef L2_TAG_CHECK_EN
    logic [ntags-1:0] busy;

    assign dat_ok = busy[i_dat_tag];

    // Set and clear never target the same tag: a tag awaiting hand-off is not in the free list.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= '0;
            o_err <= 1'b0;
        end else begin
            if (req_acc) busy[head_tag] <= 1'b1;
            if (rsp_hs)  busy[rsp_tag]  <= 1'b0;
            if (dat_acc && !dat_ok) o_err <= 1'b1;
        end
    end
`else
    assign dat_ok = 1'b1;
    assign o_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ntags; i++) sid_tbl[i] <= '0;
        end else if (req_acc) begin
            sid_tbl[head_tag] <= i_req_sid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_cmd_v   <= 1'b0;
            o_cmd_tag <= '0;
            o_cmd_ea  <= '0;
        end else if (req_acc) begin
            o_cmd_v   <= 1'b1;
            o_cmd_tag <= head_tag;
            o_cmd_ea  <= i_req_ea;
        end else if (cmd_hs) begin
            o_cmd_v   <= 1'b0;
        end
    end

    // A dropped (idle-tag) response still lets a pending hand-off complete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rsp_v   <= 1'b0;
            o_rsp_sid <= '0;
            o_rsp_d   <= '0;
            rsp_tag   <= '0;
        end else if (dat_acc && dat_ok) begin
            o_rsp_v   <= 1'b1;
            o_rsp_sid <= sid_tbl[i_dat_tag];
            o_rsp_d   <= i_dat_d;
            rsp_tag   <= i_dat_tag;
        end else if (rsp_hs) begin
            o_rsp_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_host_tag_ctrl.sv
// tb/tb_l2_host_tag_ctrl.sv - directed self-checking bench for l2_host_tag_ctrl
module tb_l2_host_tag_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req_v;
    logic          i_req_r;
    logic [5:0]    i_req_sid;
    logic [63:0]   i_req_ea;
    logic          o_cmd_v;
    logic          o_cmd_r;
    logic [4:0]    o_cmd_tag;
    logic [63:0]   o_cmd_ea;
    logic          i_dat_v;
    logic          i_dat_r;
    logic [4:0]    i_dat_tag;
    logic [1023:0] i_dat_d;
    logic          o_rsp_v;
    logic          o_rsp_r;
    logic [5:0]    o_rsp_sid;
    logic [1023:0] o_rsp_d;
    logic [5:0]    o_free_cnt;
    logic          o_err;

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    l2_host_tag_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_req_sid  (i_req_sid),
        .i_req_ea   (i_req_ea),
        .o_cmd_v    (o_cmd_v),
        .o_cmd_r    (o_cmd_r),
        .o_cmd_tag  (o_cmd_tag),
        .o_cmd_ea   (o_cmd_ea),
        .i_dat_v    (i_dat_v),
        .i_dat_r    (i_dat_r),
        .i_dat_tag  (i_dat_tag),
        .i_dat_d    (i_dat_d),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_r    (o_rsp_r),
        .o_rsp_sid  (o_rsp_sid),
        .o_rsp_d    (o_rsp_d),
        .o_free_cnt (o_free_cnt),
        .o_err      (o_err)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [1023:0] pat(input int t);
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[32*i +: 32] = 32'hA500_0000 ^ (t << 8) ^ i;
        return v;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_v"},   64'(o_cmd_v),    64'(0));
        chk({tag, "_rsp_v"},   64'(o_rsp_v),    64'(0));
        chk({tag, "_req_r"},   64'(i_req_r),    64'(0));
        chk({tag, "_dat_r"},   64'(i_dat_r),    64'(0));
        chk({tag, "_free"},    64'(o_free_cnt), 64'(0));
        chk({tag, "_err"},     64'(o_err),      64'(0));
        chk({tag, "_cmd_tag"}, 64'(o_cmd_tag),  64'(0));
        chk({tag, "_cmd_ea"},  o_cmd_ea,        64'(0));
        chk({tag, "_rsp_sid"}, 64'(o_rsp_sid),  64'(0));
        chk({tag, "_rsp_d0"},  64'(o_rsp_d === '0), 64'(1));
    endtask

    initial begin
        int init_bad;
        int bp_bad;
        int reo [3];
        reo = '{7, 2, 31};
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0; o_cmd_r = 1'b0;
        i_dat_v = 1'b0; i_dat_tag = '0; i_dat_d = '0; o_rsp_r = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");

        // INIT: cycles 1..32 not ready, RUN from cycle 33
        reset = 1'b1;
        init_bad = 0;
        for (int c = 1; c <= 32; c++) begin
            #1;
            if (i_req_r !== 1'b0 || i_dat_r !== 1'b0) init_bad++;
            if (c == 17) chk("init_cnt_mid", 64'(o_free_cnt), 64'(16));
            @(negedge clk);
        end
        chk("init_ready_low", 64'(init_bad), 64'(0));
        chk("init_free_cnt", 64'(o_free_cnt), 64'(32));
        chk("init_req_r", 64'(i_req_r), 64'(1));
        chk("init_dat_r", 64'(i_dat_r), 64'(1));

        // 32 back-to-back requests take tags 0..31 in order
        o_cmd_r = 1'b1;
        for (int i = 0; i < 32; i++) begin
            i_req_v = 1'b1; i_req_sid = 6'd5; i_req_ea = 64'(32'h1000 + 128 * i);
            @(negedge clk);
            chk("burst_cmd_v", 64'(o_cmd_v), 64'(1));
            chk("burst_tag", 64'(o_cmd_tag), 64'(i));
            chk("burst_ea", o_cmd_ea, 64'(32'h1000 + 128 * i));
        end
        i_req_v = 1'b0;
        #1;
        chk("full_req_r", 64'(i_req_r), 64'(0));
        chk("full_cnt", 64'(o_free_cnt), 64'(0));

        // out-of-order responses 7, 2, 31
        o_rsp_r = 1'b1;
        i_dat_v = 1'b1; i_dat_tag = 5'd7; i_dat_d = pat(7);
        @(negedge clk);
        chk("reo7_v", 64'(o_rsp_v), 64'(1));
        chk("reo7_sid", 64'(o_rsp_sid), 64'(5));
        chk("reo7_d", 64'(o_rsp_d === pat(7)), 64'(1));
        i_dat_tag = 5'd2; i_dat_d = pat(2);
        @(negedge clk);
        chk("reo2_sid", 64'(o_rsp_sid), 64'(5));
        chk("reo2_d", 64'(o_rsp_d === pat(2)), 64'(1));
        chk("reo2_cnt", 64'(o_free_cnt), 64'(1));
        i_dat_tag = 5'd31; i_dat_d = pat(31);
        @(negedge clk);
        chk("reo31_d", 64'(o_rsp_d === pat(31)), 64'(1));
        chk("reo31_cnt", 64'(o_free_cnt), 64'(2));
        i_dat_v = 1'b0;
        @(negedge clk);
        chk("reo_rsp_idle", 64'(o_rsp_v), 64'(0));
        chk("reo_cnt", 64'(o_free_cnt), 64'(3));

        // freed tags are reissued in freeing order
        for (int i = 0; i < 3; i++) begin
            i_req_v = 1'b1; i_req_sid = 6'(9 + i); i_req_ea = 64'(32'h9000 + 128 * i);
            @(negedge clk);
            chk("reissue_tag", 64'(o_cmd_tag), 64'(reo[i]));
            chk("reissue_ea", o_cmd_ea, 64'(32'h9000 + 128 * i));
        end
        i_req_v = 1'b0;
        #1;
        chk("reissue_cnt", 64'(o_free_cnt), 64'(0));

        // full list: pending request waits for the freed tag
        i_dat_v = 1'b1; i_dat_tag = 5'd31; i_dat_d = pat(131);
        i_req_v = 1'b1; i_req_sid = 6'd12; i_req_ea = 64'hA000;
        #1;
        chk("fl_req_r_a", 64'(i_req_r), 64'(0));
        @(negedge clk);
        chk("fl_rsp_sid", 64'(o_rsp_sid), 64'(11));
        i_dat_v = 1'b0;
        #1;
        chk("fl_req_r_b", 64'(i_req_r), 64'(0));
        @(negedge clk);
        chk("fl_req_r_c", 64'(i_req_r), 64'(1));
        chk("fl_cnt_1", 64'(o_free_cnt), 64'(1));
        @(negedge clk);
        i_req_v = 1'b0;
        chk("fl_cmd_v", 64'(o_cmd_v), 64'(1));
        chk("fl_cmd_tag", 64'(o_cmd_tag), 64'(31));
        chk("fl_cmd_ea", o_cmd_ea, 64'hA000);
        chk("fl_cnt_0", 64'(o_free_cnt), 64'(0));

        // response backpressure: one capture, then hold
        o_rsp_r = 1'b0;
        i_dat_v = 1'b1; i_dat_tag = 5'd7; i_dat_d = pat(77);
        @(negedge clk);
        chk("bp_sid", 64'(o_rsp_sid), 64'(9));
        chk("bp_dat_r_low", 64'(i_dat_r), 64'(0));
        i_dat_tag = 5'd2; i_dat_d = pat(22);
        bp_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd9 || o_rsp_d !== pat(77) ||
                i_dat_r !== 1'b0 || o_free_cnt !== 6'd0) bp_bad++;
        end
        chk("bp_hold", 64'(bp_bad), 64'(0));
        o_rsp_r = 1'b1;
        #1;
        chk("bp_dat_r_high", 64'(i_dat_r), 64'(1));
        @(negedge clk);
        chk("bp_next_sid", 64'(o_rsp_sid), 64'(10));
        chk("bp_next_d", 64'(o_rsp_d === pat(22)), 64'(1));
        chk("bp_cnt_1", 64'(o_free_cnt), 64'(1));
        i_dat_v = 1'b0;
        @(negedge clk);
        chk("bp_rsp_idle", 64'(o_rsp_v), 64'(0));
        chk("bp_cnt_2", 64'(o_free_cnt), 64'(2));

        // command backpressure holds the command and blocks allocation
        o_cmd_r = 1'b0;
        i_req_v = 1'b1; i_req_sid = 6'd20; i_req_ea = 64'hB000;
        @(negedge clk);
        chk("cbp_tag", 64'(o_cmd_tag), 64'(7));
        chk("cbp_req_r", 64'(i_req_r), 64'(0));
        i_req_v = 1'b0;
        @(negedge clk);
        chk("cbp_hold_v", 64'(o_cmd_v), 64'(1));
        chk("cbp_hold_ea", o_cmd_ea, 64'hB000);
        o_cmd_r = 1'b1;
        @(negedge clk);
        chk("cbp_done_v", 64'(o_cmd_v), 64'(0));
        chk("cbp_cnt", 64'(o_free_cnt), 64'(1));

`ifdef L2_TAG_CHECK_EN
        // tag 2 is in the free list, so a response to it is dropped
        i_dat_v = 1'b1; i_dat_tag = 5'd2; i_dat_d = pat(2);
        #1;
        chk("tc_dat_r", 64'(i_dat_r), 64'(1));
        @(negedge clk);
        i_dat_v = 1'b0;
        chk("tc_rsp_v", 64'(o_rsp_v), 64'(0));
        chk("tc_err", 64'(o_err), 64'(1));
        chk("tc_cnt", 64'(o_free_cnt), 64'(1));
        @(negedge clk);
        chk("tc_err_sticky", 64'(o_err), 64'(1));
`else
        chk("err_tied", 64'(o_err), 64'(0));
`endif

        // asynchronous reset with command and response both pending
        o_cmd_r = 1'b0; o_rsp_r = 1'b0;
        i_req_v = 1'b1; i_req_sid = 6'd3; i_req_ea = 64'hC000;
        i_dat_v = 1'b1; i_dat_tag = 5'd7; i_dat_d = pat(7);
        @(negedge clk);
        chk("mr_cmd_v", 64'(o_cmd_v), 64'(1));
        chk("mr_cmd_tag", 64'(o_cmd_tag), 64'(2));
        chk("mr_rsp_sid", 64'(o_rsp_sid), 64'(20));
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("mr");
        i_req_v = 1'b0; i_dat_v = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (32) @(negedge clk);
        chk("mr_reinit_cnt", 64'(o_free_cnt), 64'(32));
        chk("mr_reinit_req_r", 64'(i_req_r), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
